// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: drives CRC_7 for a command header, then serialises the 48-bit SD CMD frame MSB-first.
// Optional macro SD_CMD_FIXED_CRC_EN: CMD0 (index 0, arg 0) bypasses CRC_7 and uses the constant 7'h4A.
module sd_cmd_sequencer #(
   parameter int BIT_DIV     = 1,
   parameter int CRC_TIMEOUT = 63,
   parameter int GAP_BITS    = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cmd_start,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        cmd_busy,
   output logic        cmd_sent,
   output logic        cmd_err,
   output logic        cmd_line,
   output logic        cmd_oe,
   output logic        crc_enable,
   output logic [39:0] crc_data,
   input  logic [6:0]  crc_value,
   input  logic        crc_done
);
   typedef enum logic [2:0] {IDLE, LOAD, CRC_RUN, SHIFT, GAP, DONE} state_t;
   state_t      state_q, state_d;
   logic [39:0] crc_data_q, crc_data_d;
   logic [6:0]  crc_q, crc_d;
   logic [5:0]  bit_q, bit_d;
   logic [7:0]  div_q, div_d;
   logic [15:0] cnt_q, cnt_d;
   logic        busy_q, busy_d, sent_q, sent_d, err_q, err_d;
   logic        line_q, line_d, oe_q, oe_d, en_q, en_d;
   logic [47:0] frame;
   // The CRC_7 header is exactly the top 40 bits of the frame.
   assign frame = {crc_data_q, crc_q, 1'b1};
   always_comb begin
      state_d    = state_q;
      crc_data_d = crc_data_q;
      crc_d      = crc_q;
      bit_d      = bit_q;
      div_d      = div_q;
      cnt_d      = cnt_q;
      line_d     = line_q;
      oe_d       = oe_q;
      en_d       = en_q;
      sent_d     = 1'b0;
      err_d      = 1'b0;
      case (state_q)
         IDLE: if (cmd_start && !busy_q) begin
            crc_data_d = {2'b01, cmd_index, cmd_arg};
            state_d    = LOAD;
         end
         LOAD: begin
`ifdef SD_CMD_FIXED_CRC_EN
            if (crc_data_q[37:0] == '0) begin
               crc_d   = 7'h4A;
               state_d = SHIFT;
               bit_d   = 6'd47;
               div_d   = '0;
               oe_d    = 1'b1;
               line_d  = crc_data_q[39];
            end else
`endif
            begin
               state_d = CRC_RUN;
               en_d    = 1'b1;
               cnt_d   = '0;
            end
         end
         CRC_RUN: if (crc_done) begin
            crc_d   = crc_value;
            en_d    = 1'b0;
            state_d = SHIFT;
            bit_d   = 6'd47;
            div_d   = '0;
            oe_d    = 1'b1;
            line_d  = crc_data_q[39];
         end else if (cnt_q == 16'(CRC_TIMEOUT - 1)) begin
            en_d    = 1'b0;
            err_d   = 1'b1;
            state_d = IDLE;
         end else cnt_d = cnt_q + 16'd1;
         SHIFT: if (div_q != 8'(BIT_DIV - 1)) div_d = div_q + 8'd1;
         else if (bit_q == '0) begin
            state_d = GAP;
            div_d   = '0;
            oe_d    = 1'b0;
            line_d  = 1'b1;
            cnt_d   = '0;
         end else begin
            div_d  = '0;
            bit_d  = bit_q - 6'd1;
            line_d = frame[bit_d];
         end
         GAP: if (cnt_q == 16'(GAP_BITS * BIT_DIV - 1)) begin
            state_d = DONE;
            sent_d  = 1'b1;
            cnt_d   = '0;
         end else cnt_d = cnt_q + 16'd1;
         default: state_d = IDLE;
      endcase
      // Busy stays up through the cmd_err cycle so a start there is ignored.
      busy_d = (state_d != IDLE) || err_d;
   end
   always_ff @(posedge CLK)
      if (RST) begin
         state_q    <= IDLE;
         crc_data_q <= '0;
         crc_q      <= '0;
         bit_q      <= '0;
         div_q      <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         sent_q     <= 1'b0;
         err_q      <= 1'b0;
         line_q     <= 1'b1;
         oe_q       <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_data_q <= crc_data_d;
         crc_q      <= crc_d;
         bit_q      <= bit_d;
         div_q      <= div_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         sent_q     <= sent_d;
         err_q      <= err_d;
         line_q     <= line_d;
         oe_q       <= oe_d;
         en_q       <= en_d;
      end
   assign cmd_busy   = busy_q;
   assign cmd_sent   = sent_q;
   assign cmd_err    = err_q;
   assign cmd_line   = line_q;
   assign cmd_oe     = oe_q;
   assign crc_enable = en_q;
   assign crc_data   = crc_data_q;
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: scoreboard bench, one sequencer at BIT_DIV=1 and one at BIT_DIV=4, each with a CRC_7 stand-in.
module tb_sd_cmd_sequencer;
`ifdef SD_CMD_FIXED_CRC_EN
   localparam bit FIX = 1'b1;
`else
   localparam bit FIX = 1'b0;
`endif
   logic CLK = 1'b0, RST = 1'b1, crc_dead = 1'b0;
   always #5 CLK = ~CLK;
   logic [1:0]        start = '0, busy, sent, err, line, oe, crc_en, done;
   logic [1:0][5:0]   idx = '0;
   logic [1:0][31:0]  arg = '0;
   logic [1:0][39:0]  cdata;
   logic [1:0][6:0]   cval;
   int vectors = 0, miscompares = 0;
   typedef struct {
      int          id;
      bit          is_err;
      logic [47:0] frame;
      logic [39:0] cd;
      int          lat;
      int          en_rises;
   } exp_t;
   exp_t sbq[$];
   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask
   function automatic logic [6:0] crc_tab(input logic [39:0] d);
      return d == 40'h4000000000 ? 7'h4A : d == 40'h5100000000 ? 7'h2A : d == 40'h48000001AA ? 7'h43 : 7'h00;
   endfunction
   for (genvar g = 0; g < 2; g++) begin : u
      localparam int D = (g == 0) ? 1 : 4;
      logic [3:0] cc;
      sd_cmd_sequencer #(.BIT_DIV(D)) dut (
         .CLK(CLK), .RST(RST), .cmd_start(start[g]), .cmd_index(idx[g]), .cmd_arg(arg[g]),
         .cmd_busy(busy[g]), .cmd_sent(sent[g]), .cmd_err(err[g]), .cmd_line(line[g]), .cmd_oe(oe[g]),
         .crc_enable(crc_en[g]), .crc_data(cdata[g]), .crc_value(cval[g]), .crc_done(done[g])
      );
      // CRC_7 stand-in: done on the third enabled cycle.
      always_ff @(posedge CLK)
         if (!crc_en[g] || crc_dead) begin
            cc      <= '0;
            done[g] <= 1'b0;
         end else begin
            cc      <= cc + 4'd1;
            done[g] <= (cc == 4'd1);
         end
      assign cval[g] = crc_tab(cdata[g]);
      initial begin : mon
         automatic int oe_n = 0, gap_n = 0, lat = 0, hold_bad = 0, gap_bad = 0, en_r = 0;
         automatic logic p_busy = 1'b0, p_en = 1'b0, held = 1'b0, err_pend = 1'b0, en_ld = 1'b0;
         automatic logic [47:0] fr = '0;
         automatic logic [39:0] cd = '0;
         automatic exp_t e;
         forever begin
            @(posedge CLK);
            #1;
            if (RST) begin
               p_busy = 1'b0; p_en = 1'b0; err_pend = 1'b0; oe_n = 0;
               continue;
            end
            if (err_pend) chk("err_then_idle", {busy[g], err[g]}, 2'b00);
            err_pend = 1'b0;
            if (busy[g] && !p_busy) begin
               lat = 0; oe_n = 0; gap_n = 0; hold_bad = 0; gap_bad = 0; en_r = 0; fr = '0;
               en_ld = crc_en[g]; cd = cdata[g];
            end else lat++;
            if (crc_en[g] && !p_en) en_r++;
            if (oe[g]) begin
               if (oe_n % D == 0) begin
                  fr = {fr[46:0], line[g]};
                  held = line[g];
               end else if (line[g] !== held) hold_bad++;
               oe_n++;
            end else if (busy[g] && oe_n > 0 && !sent[g]) begin
               gap_n++;
               if (line[g] !== 1'b1) gap_bad++;
            end
            if (sent[g] || err[g]) begin
               if (sbq.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_output u%0d: sent=%b err=%b with empty scoreboard", g, sent[g], err[g]);
               end else begin
                  e = sbq.pop_front();
                  chk("instance", g, e.id);
                  chk("kind", {sent[g], err[g]}, e.is_err ? 2'b01 : 2'b10);
                  chk("latency", lat, e.lat);
                  chk("crc_data", cd, e.cd);
                  chk("en_at_load", en_ld, 1'b0);
                  chk("en_rises", en_r, e.en_rises);
                  if (e.is_err) begin
                     chk("oe_cycles_on_err", oe_n, 0);
                     err_pend = 1'b1;
                  end else begin
                     chk("frame", fr, e.frame);
                     chk("oe_cycles", oe_n, 48 * D);
                     chk("gap_cycles", gap_n, 8 * D);
                     chk("bit_hold", hold_bad, 0);
                     chk("gap_line", gap_bad, 0);
                  end
               end
            end
            p_busy = busy[g];
            p_en = crc_en[g];
         end
      end
   end
   task automatic push(input int id, input bit e, input logic [47:0] f, input logic [39:0] cd, input int lat, input int en);
      sbq.push_back('{id, e, f, cd, lat, en});
   endtask
   task automatic issue(input int g, input logic [5:0] i, input logic [31:0] a);
      start[g] = 1'b1;
      idx[g] = i;
      arg[g] = a;
      @(negedge CLK);
      start[g] = 1'b0;
   endtask
   task automatic wait_end(input int g, input string nm);
      int n = 0;
      while (!(sent[g] || err[g]) && n < 3000) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 3000) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: no cmd_sent/cmd_err within 3000 cycles", nm);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      repeat (3) @(negedge CLK);
      chk("rst_busy", busy[0], 1'b0);
      chk("rst_sent", sent[0], 1'b0);
      chk("rst_err", err[0], 1'b0);
      chk("rst_line", line[0], 1'b1);
      chk("rst_oe", oe[0], 1'b0);
      chk("rst_crc_en", crc_en[0], 1'b0);
      chk("rst_crc_data", cdata[0], 40'h0);
      RST = 1'b0;
      @(negedge CLK);
      // CMD0
      push(0, 0, 48'h400000000095, 40'h4000000000, FIX ? 57 : 60, FIX ? 0 : 1);
      issue(0, 6'd0, 32'h0);
      wait_end(0, "cmd0");
      // CMD17 then CMD8 back-to-back, with an ignored start while busy
      @(negedge CLK);
      push(0, 0, 48'h510000000055, 40'h5100000000, 60, 1);
      issue(0, 6'd17, 32'h0);
      repeat (10) @(negedge CLK);
      issue(0, 6'd5, 32'hDEADBEEF);
      wait_end(0, "cmd17");
      @(negedge CLK);
      push(0, 0, 48'h48000001AA87, 40'h48000001AA, 60, 1);
      issue(0, 6'd8, 32'h1AA);
      wait_end(0, "cmd8");
      // CRC never completes
      @(negedge CLK);
      crc_dead = 1'b1;
      push(0, 1, 48'h0, 40'h5100000000, 64, 1);
      issue(0, 6'd17, 32'h0);
      wait_end(0, "timeout");
      repeat (2) @(negedge CLK);
      chk("crc_data_kept_after_err", cdata[0], 40'h5100000000);
      crc_dead = 1'b0;
      // BIT_DIV=4
      push(1, 0, 48'h400000000095, 40'h4000000000, FIX ? 225 : 228, FIX ? 0 : 1);
      issue(1, 6'd0, 32'h0);
      wait_end(1, "cmd0_div4");
      // Reset in the middle of SHIFT
      @(negedge CLK);
      issue(0, 6'd8, 32'h1AA);
      for (int n = 0; n < 500 && !oe[0]; n++) @(negedge CLK);
      chk("oe_rise", oe[0], 1'b1);
      repeat (27) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("midrst_line", line[0], 1'b1);
      chk("midrst_oe", oe[0], 1'b0);
      chk("midrst_busy", busy[0], 1'b0);
      start[0] = 1'b1;
      idx[0] = 6'd17;
      arg[0] = 32'h0;
      @(negedge CLK);
      chk("start_during_rst_ignored", busy[0], 1'b0);
      RST = 1'b0;
      push(0, 0, 48'h510000000055, 40'h5100000000, 60, 1);
      @(negedge CLK);
      start[0] = 1'b0;
      chk("start_after_rst_accepted", busy[0], 1'b1);
      wait_end(0, "cmd17_after_rst");
      repeat (3) @(negedge CLK);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/sd_cmd_sequencer.md
Name: sd_cmd_sequencer

Overview:
- Sequences the CRC_7 generator for SD-card command transmission in the boot path.
- Accepts a command index plus 32-bit argument, loads the 40-bit header into CRC_7, and waits for done. Captures the CRC7 and serialises the 48-bit frame MSB-first onto the CMD line.
- Sits between the boot FSM (requester) and the SD CMD pin; CRC_7 is an external instance driven through the crc_* ports.

Parameters:
- BIT_DIV, 1, CLK cycles per CMD bit (1..255).
- CRC_TIMEOUT, 63, max CLK cycles in CRC_RUN before abort.
- GAP_BITS, 8, idle bit-periods (line high) after the frame, before the next command is accepted.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- cmd_start  in  1  one-cycle request; sampled only in IDLE.
- cmd_index  in  6  command index, captured with cmd_start.
- cmd_arg  in  32  argument, captured with cmd_start.
- cmd_busy  out  1  high from the cycle after an accepted start until the cycle after cmd_sent/cmd_err.
- cmd_sent  out  1  one-cycle pulse: frame plus gap complete.
- cmd_err  out  1  one-cycle pulse: CRC timeout, no frame sent.
- cmd_line  out  1  serial CMD data; idles 1.
- cmd_oe  out  1  CMD driver enable; high only while frame bits are driven.
- crc_enable  out  1  to CRC_7 Enable.
- crc_data  out  40  to CRC_7 data_i = {1'b0,1'b1,index,arg}.
- crc_value  in  7  from CRC_7 CRC.
- crc_done  in  1  from CRC_7 done.

Behaviour:
- Reset values, applied at the next CLK edge with RST=1 (including mid-operation):
  - Outputs: cmd_busy=0, cmd_sent=0, cmd_err=0, cmd_line=1, cmd_oe=0, crc_enable=0, crc_data=0.
  - State: IDLE; all counters 0.
- IDLE: on cmd_start=1, latch index/arg, load crc_data, go to LOAD; cmd_busy=1 from the next cycle. cmd_start while busy is ignored, not queued.
- LOAD (1 cycle): crc_enable=0 with crc_data stable. This guarantees CRC_7 sees Enable low before each run, so back-to-back commands restart the engine.
- CRC_RUN:
  - crc_enable=1; a timeout counter increments each cycle.
  - On the first cycle with crc_done=1: capture crc_value into crc_q, then go to SHIFT.
  - crc_enable=0 from the following cycle.
  - If the counter reaches CRC_TIMEOUT with no crc_done: pulse cmd_err, drop crc_enable, go to IDLE. cmd_oe is never asserted on this path.
  - If crc_done and the timeout occur in the same cycle, crc_done wins.
- SHIFT:
  - Frame = {2'b01, index, arg, crc_q, 1'b1}, 48 bits, sent MSB first.
  - Each bit is held BIT_DIV cycles; cmd_oe=1 for exactly 48*BIT_DIV cycles.
  - Bit counter 47 down to 0; no wrap; exit after the bit-0 period.
- GAP: cmd_oe=0, cmd_line=1 for GAP_BITS*BIT_DIV cycles.
- DONE (1 cycle): cmd_sent=1, then IDLE. cmd_busy is low in the IDLE cycle.
- crc_data holds its value from LOAD until the next accepted start.
- crc_data is not cleared on cmd_err.
- Total latency, start to cmd_sent, with BIT_DIV=1: 1 (LOAD) + N_run + 48 + GAP_BITS + 1.

Optional Feature:
- Macro SD_CMD_FIXED_CRC_EN.
- Defined: when the latched index=0 and arg=0 (CMD0), skip CRC_RUN. crc_q is set to 7'h4A and the block goes LOAD→SHIFT; crc_enable stays 0 for that command. All other commands behave as normal.
- Undefined: every command, including CMD0, goes through CRC_7; no constant table is present.

Test Plan:
- CMD0 (index 0, arg 0), BIT_DIV=1, CRC_7 model returns 7'h4A: serial stream is 0x400000000095 MSB-first with cmd_oe high for 48 cycles. cmd_sent pulses 8 cycles after the last bit, and crc_data equals 40'h4000000000.
- CMD17 (index 17, arg 0), then CMD8 (index 8, arg 32'h1AA) issued back-to-back on the cycle after cmd_sent:
  - CMD17: crc_data=40'h5100000000, crc 7'h2A, frame ends byte 0x55.
  - CMD8: crc_data=40'h48000001AA, crc 7'h43, frame ends byte 0x87.
  - crc_enable is low for at least 1 cycle between the two runs.
- crc_done tied 0: after CRC_TIMEOUT cycles in CRC_RUN, cmd_err pulses once, cmd_oe stays 0 throughout, and cmd_busy falls.
- BIT_DIV=4, CMD0: each bit is held 4 cycles, cmd_oe is high for 192 cycles, and the gap is 32 cycles.
- RST asserted at bit 20 of SHIFT: next edge gives cmd_line=1, cmd_oe=0, cmd_busy=0. A cmd_start asserted the same cycle RST is released is ignored; a cmd_start one cycle later is accepted.
- With SD_CMD_FIXED_CRC_EN, CMD0: crc_enable never rises and the frame still ends with byte 0x95. Run the same bench with the macro undefined: crc_enable does rise for CMD0.
